// File: rtl/mem_pkg.sv
// Shared types and helpers for the memory responder: FSM state, access type, and the
// byte-address-to-word-index and counter-width helpers.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE
  } state_t;

  typedef enum logic {
    OP_RD,
    OP_WR
  } op_t;

  // Word index of a byte address; kept wide so range checks never lose upper bits.
  function automatic logic [63:0] wordIndex(input logic [63:0] adr);
    return adr >> 2;
  endfunction

  function automatic int cntWidth(input int waitCycles);
    return (waitCycles > 0) ? $clog2(waitCycles + 1) : 1;
  endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Controller <-> memory responder request/response bundle.
interface mem_responder_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              MemRead;
  logic              MemWrite;
  logic [ADDR_W-1:0] Adr;
  logic [DATA_W-1:0] WriteData;
  logic [DATA_W-1:0] MemData;
  logic              MemReady;
  logic              MemErr;

  modport master (
    output MemRead, MemWrite, Adr, WriteData,
    input  MemData, MemReady, MemErr
  );

  modport slave (
    input  MemRead, MemWrite, Adr, WriteData,
    output MemData, MemReady, MemErr
  );
endinterface

// File: rtl/mem_word_array.sv
// Word-organised storage: one synchronous write port, one asynchronous read port.
module mem_word_array #(
  parameter int DATA_W      = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int IDX_W       = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [IDX_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH_WORDS];

  // NOTE: storage has no reset; clearing a RAM array is neither needed nor mappable to block RAM.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/mem_responder.sv
// Multi-cycle memory responder: accepts MemRead/MemWrite, waits WAIT_CYCLES, then completes
// with a registered MemReady pulse. Define MEM_ALIGN_CHECK_EN to reject unaligned addresses.
module mem_responder
  import mem_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input logic            clk,
  input logic            rst,
  mem_responder_if.slave bus
);

  localparam int CNT_W = cntWidth(WAIT_CYCLES);
  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  state_t            state, stateNxt;
  logic [CNT_W-1:0]  cnt;
  logic [IDX_W-1:0]  latIdx;
  logic [DATA_W-1:0] latData;
  op_t               latOp;
  logic              latErr;

  logic              request;
  logic [63:0]       reqWord;
  logic [IDX_W-1:0]  reqIdx;
  logic              reqErr;
  logic              memWe;
  logic              rdLoad;
  logic [DATA_W-1:0] rdData;

  assign request = bus.MemRead | bus.MemWrite;
  assign reqWord = wordIndex(64'(bus.Adr));
  assign reqIdx  = reqWord[IDX_W-1:0];

`ifdef MEM_ALIGN_CHECK_EN
  assign reqErr = (bus.MemRead & bus.MemWrite) | (reqWord >= 64'(DEPTH_WORDS))
                | (bus.Adr[1:0] != 2'b00);
`else
  assign reqErr = (bus.MemRead & bus.MemWrite) | (reqWord >= 64'(DEPTH_WORDS));
`endif

  // NOTE: sequential state uses <= so every flop samples pre-edge values regardless of order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= stateNxt;
  end

  // NOTE: the default assignment first keeps this combinational block from inferring a latch.
  always_comb begin
    stateNxt = state;
    unique case (state)
      IDLE:    if (request) stateNxt = (WAIT_CYCLES == 0) ? DONE : WAIT;
      WAIT:    if (cnt == CNT_W'(1)) stateNxt = DONE;
      DONE:    stateNxt = IDLE;
      default: stateNxt = IDLE;
    endcase
  end

  always_comb begin
    memWe  = (state == DONE) && !latErr && (latOp == OP_WR);
    rdLoad = (state == DONE) && !latErr && (latOp == OP_RD);
  end

  // Request is captured once in IDLE; WAIT and DONE work only from these copies.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt     <= '0;
      latIdx  <= '0;
      latData <= '0;
      latOp   <= OP_RD;
      latErr  <= 1'b0;
    end else begin
      if (state == IDLE && request) begin
        cnt     <= CNT_W'(WAIT_CYCLES);
        latIdx  <= reqIdx;
        latData <= bus.WriteData;
        latOp   <= bus.MemWrite ? OP_WR : OP_RD;
        latErr  <= reqErr;
      end else if (state == WAIT) begin
        cnt <= cnt - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.MemData  <= '0;
      bus.MemReady <= 1'b0;
      bus.MemErr   <= 1'b0;
    end else begin
      bus.MemReady <= (state == DONE);
      bus.MemErr   <= (state == DONE) && latErr;
      if (rdLoad) bus.MemData <= rdData;
    end
  end

  mem_word_array #(
    .DATA_W      (DATA_W),
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDX_W       (IDX_W)
  ) u_array (
    .clk   (clk),
    .we    (memWe),
    .waddr (latIdx),
    .wdata (latData),
    .raddr (latIdx),
    .rdata (rdData)
  );

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: two instances (WAIT_CYCLES 2 and 0) against a
// reference memory model and a queue of expected responses.
module tb_mem_responder;

  localparam int DEPTH = 64;

  typedef struct {
    string       tag;
    logic [31:0] data;
    logic        err;
  } exp_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  exp_t        sbq [$];
  logic [31:0] refMem  [2][DEPTH];
  logic [31:0] expData [2];

  mem_responder_if #(.ADDR_W(32), .DATA_W(32)) ifA ();
  mem_responder_if #(.ADDR_W(32), .DATA_W(32)) ifB ();

  mem_responder #(.ADDR_W(32), .DATA_W(32), .DEPTH_WORDS(DEPTH), .WAIT_CYCLES(2)) dutA (
    .clk (clk),
    .rst (rst),
    .bus (ifA)
  );

  mem_responder #(.ADDR_W(32), .DATA_W(32), .DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) dutB (
    .clk (clk),
    .rst (rst),
    .bus (ifB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic int waitOf(input bit b);
    return b ? 0 : 2;
  endfunction

  function automatic logic rdyOf(input bit b);
    return b ? ifB.MemReady : ifA.MemReady;
  endfunction

  function automatic logic errOf(input bit b);
    return b ? ifB.MemErr : ifA.MemErr;
  endfunction

  function automatic logic [31:0] dataOf(input bit b);
    return b ? ifB.MemData : ifA.MemData;
  endfunction

  task automatic drive(input bit b, input logic rd, input logic wr,
                       input logic [31:0] adr, input logic [31:0] wd);
    if (b) begin
      ifB.MemRead = rd; ifB.MemWrite = wr; ifB.Adr = adr; ifB.WriteData = wd;
    end else begin
      ifA.MemRead = rd; ifA.MemWrite = wr; ifA.Adr = adr; ifA.WriteData = wd;
    end
  endtask

  // Reference behaviour: update the model memory and queue the response the DUT owes us.
  task automatic predict(input bit b, input logic rd, input logic wr,
                         input logic [31:0] adr, input logic [31:0] wd, input string tag);
    exp_t e;
    logic err;
    int   idx;
    idx = int'(adr >> 2);
    err = (rd && wr) || (adr >= 32'(4 * DEPTH));
`ifdef MEM_ALIGN_CHECK_EN
    err = err || (adr[1:0] != 2'b00);
`endif
    if (!err && wr) refMem[b][idx] = wd;
    if (!err && rd) expData[b] = refMem[b][idx];
    e.tag  = tag;
    e.data = expData[b];
    e.err  = err;
    sbq.push_back(e);
  endtask

  task automatic access(input bit b, input logic rd, input logic wr,
                        input logic [31:0] adr, input logic [31:0] wd, input string tag);
    exp_t e;
    int   n;
    bit   got;
    @(negedge clk);
    drive(b, rd, wr, adr, wd);
    predict(b, rd, wr, adr, wd, tag);
    n   = 0;
    got = 1'b0;
    while (!got && n < 20) begin
      @(negedge clk);
      n++;
      got = rdyOf(b);
    end
    drive(b, 1'b0, 1'b0, adr, wd);
    check({tag, "_ready"}, 32'(got), 32'd1);
    if (got) check({tag, "_latency"}, n, waitOf(b) + 2);
    e = sbq.pop_front();
    check({tag, "_data"}, dataOf(b), e.data);
    check({tag, "_err"}, 32'(errOf(b)), 32'(e.err));
    @(negedge clk);
    check({tag, "_pulse"}, 32'(rdyOf(b)), 32'd0);
  endtask

  initial begin
    exp_t e;
    int   n;
    int   last;
    int   k;
    bit   got;

    checks = 0;
    errors = 0;
    rst    = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    expData[0] = 32'h0;
    expData[1] = 32'h0;
    repeat (3) @(negedge clk);
    check("rstA_data", ifA.MemData, 32'h0);
    check("rstA_ready", 32'(ifA.MemReady), 32'd0);
    check("rstA_err", 32'(ifA.MemErr), 32'd0);
    check("rstB_data", ifB.MemData, 32'h0);
    check("rstB_ready", 32'(ifB.MemReady), 32'd0);
    rst = 1'b1;

    // Reset in the middle of a store's wait phase abandons it entirely.
    access(1'b0, 1'b0, 1'b1, 32'h10, 32'h1111_2222, "sw10");
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b1, 32'h10, 32'hBADB_AD00);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    check("abort_ready", 32'(ifA.MemReady), 32'd0);
    check("abort_data", ifA.MemData, 32'h0);
    expData[0] = 32'h0;
    expData[1] = 32'h0;
    @(negedge clk);
    rst = 1'b1;
    got = 1'b0;
    repeat (6) begin
      @(negedge clk);
      got = got | ifA.MemReady;
    end
    check("abort_noready", 32'(got), 32'd0);
    access(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, "lw10_after_abort");

    // Basic store/load with two wait cycles.
    access(1'b0, 1'b0, 1'b1, 32'h40, 32'hDEAD_BEEF, "sw40");
    access(1'b0, 1'b1, 1'b0, 32'h40, 32'h0, "lw40");

    // Zero-wait instance: back-to-back loads complete every second cycle, in order.
    for (int i = 0; i < 4; i++) access(1'b1, 1'b0, 1'b1, 32'(i * 4), 32'hA0 + 32'(i), "b_sw");
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b0, 32'h0, 32'h0);
    for (int i = 0; i < 4; i++) predict(1'b1, 1'b1, 1'b0, 32'(i * 4), 32'h0, "b2b");
    n    = 0;
    last = 0;
    k    = 0;
    while (k < 4 && n < 40) begin
      @(negedge clk);
      n++;
      if (ifB.MemReady) begin
        e = sbq.pop_front();
        check("b2b_data", ifB.MemData, e.data);
        check("b2b_gap", n - last, 2);
        last = n;
        k++;
        if (k < 4) ifB.Adr = 32'(k * 4);
        else       ifB.MemRead = 1'b0;
      end
    end
    check("b2b_count", k, 4);

    // Simultaneous read and write is rejected without side effects.
    access(1'b0, 1'b0, 1'b1, 32'h8, 32'h1234_5678, "sw8");
    access(1'b0, 1'b1, 1'b0, 32'h40, 32'h0, "lw40_again");
    access(1'b0, 1'b1, 1'b1, 32'h8, 32'hFFFF_0000, "rdwr_err");
    access(1'b0, 1'b1, 1'b0, 32'h8, 32'h0, "lw8");

    // Range boundary: last word works, one past it errors and never wraps to word 0.
    access(1'b0, 1'b0, 1'b1, 32'h0, 32'h0BAD_F00D, "sw0");
    access(1'b0, 1'b0, 1'b1, 32'hFC, 32'hCAFE_F00D, "swFC");
    access(1'b0, 1'b1, 1'b0, 32'hFC, 32'h0, "lwFC");
    access(1'b0, 1'b1, 1'b0, 32'h100, 32'h0, "lw_oor");
    access(1'b0, 1'b0, 1'b1, 32'h100, 32'h0000_0001, "sw_oor");
    access(1'b0, 1'b1, 1'b0, 32'h0, 32'h0, "lw0");

    // Unaligned store: rejected with alignment checking, otherwise lands on the word.
    access(1'b0, 1'b0, 1'b1, 32'h4, 32'h0000_0077, "sw4");
    access(1'b0, 1'b0, 1'b1, 32'h6, 32'h0000_0055, "sw6");
    access(1'b0, 1'b1, 1'b0, 32'h4, 32'h0, "lw4");

    check("sb_empty", 32'(sbq.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
